// File: rtl/lly_seq_pkg.sv
// Shared types and widths for the serial pattern generator.
// Holds the FSM state encoding and the widths of the len/rep fields.
package lly_seq_pkg;

  localparam int SEQ_WIDTH_DEF = 8;
  localparam int LEN_W         = 4;
  localparam int REP_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // A zero or oversized length means "use the full register width".
  function automatic int eff_len(input logic [LEN_W-1:0] len, input int width);
    return ((len == '0) || (int'(len) > width)) ? width : int'(len);
  endfunction

endpackage

// File: rtl/lly_piso_shift.sv
// Parallel-in serial-out shifter, MSB out first; o_msb is a flop output.
// Clear beats load, load beats shift; zeros shift in behind the data.
module lly_piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= r_sh << 1;
    end
  end

  assign o_msb = r_sh[WIDTH-1];

endmodule

// File: rtl/lly_seq_gen.sv
// Serial pattern generator: repeats a captured frame rep times (0 = forever) with GAP idle cycles between.
// First bit one cycle after start; no backpressure, stop aborts to IDLE without a done pulse.
module lly_seq_gen
  import lly_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEF,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] rep,
  output logic             dout,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  seq_state_e       r_state;
  logic [WIDTH-1:0] r_pat;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] r_frame_cnt;
  logic [GAP_W-1:0] r_gap_cnt;

  logic [CNT_W-1:0] w_len_eff;
  logic [WIDTH-1:0] w_pat_aligned;
  logic             w_accept;
  logic             w_frame_end;
  logic             w_last_frame;
  logic             w_gap_end;
  logic             w_reload;
  logic             w_load;
  logic             w_shift;
  logic             w_clear;
  logic [WIDTH-1:0] w_load_dat;

  // Left-align the active bits so the shifter always emits from its MSB.
  assign w_len_eff     = CNT_W'(eff_len(len, WIDTH));
  assign w_pat_aligned = pattern << (WIDTH - int'(w_len_eff));

  assign w_accept     = (r_state == ST_IDLE) && start && !stop;
  assign w_frame_end  = (r_state == ST_SEND) && !stop && (r_bit_cnt == '0);
  assign w_last_frame = (r_rep != '0) && (r_frame_cnt == r_rep - 1'b1);
  assign w_gap_end    = (r_state == ST_GAP) && !stop && (r_gap_cnt == '0);
  assign w_reload     = (w_frame_end && !w_last_frame && (GAP == 0)) || w_gap_end;

  assign w_load     = w_accept || w_reload;
  assign w_load_dat = w_accept ? w_pat_aligned : r_pat;
  assign w_shift    = (r_state == ST_SEND) && !stop && !w_reload;
  assign w_clear    = stop && ((r_state == ST_SEND) || (r_state == ST_GAP));

  lly_piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_dat),
    .o_msb   (dout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pat       <= '0;
      r_len       <= '0;
      r_bit_cnt   <= '0;
      r_rep       <= '0;
      r_frame_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pat       <= w_pat_aligned;
            r_len       <= w_len_eff;
            r_rep       <= rep;
            r_bit_cnt   <= w_len_eff - 1'b1;
            r_frame_cnt <= '0;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (r_bit_cnt == '0) begin
            // Saturate so continuous mode never wraps into a false final frame.
            if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_last_frame) begin
              r_state <= ST_DONE;
            end else if (GAP > 0) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GAP_W'((GAP > 0) ? GAP - 1 : 0);
            end else begin
              r_bit_cnt <= r_len - 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (r_gap_cnt == '0) begin
            r_state   <= ST_SEND;
            r_bit_cnt <= r_len - 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bit_valid = (r_state == ST_SEND);
  assign busy      = (r_state == ST_SEND) || (r_state == ST_GAP);
  assign done      = (r_state == ST_DONE);

endmodule

// File: doc/lly_seq_gen.md
LLY_SEQ_GEN -- requirements
Module: lly_seq_gen

Interface
REQ-001 Parameter WIDTH, default 8: maximum pattern length in bits.
REQ-002 Parameter GAP, default 0: idle cycles inserted between repeated frames.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin transmission; sampled only in IDLE.
REQ-006 stop  input  1  abort the current transmission.
REQ-007 pattern  input  WIDTH  bits to send; pattern[len-1] is sent first, pattern[0] last.
REQ-008 len  input  4  active bit count; 0 or >WIDTH treated as WIDTH.
REQ-009 rep  input  4  number of frames to send; 0 means continuous until stop.
REQ-010 dout  output  1  serial data, registered.
REQ-011 bit_valid  output  1  high in every cycle where dout carries a pattern bit.
REQ-012 busy  output  1  high in SEND and GAP states.
REQ-013 done  output  1  one-cycle pulse after the final frame completes normally.

Function
REQ-014 States: IDLE, SEND, GAP, DONE.
REQ-015 IDLE: dout=0, bit_valid=0, busy=0, done=0.
REQ-016 IDLE with start=1 and stop=0: capture pattern, effective len and rep; go to SEND next cycle.
REQ-017 The first bit appears on dout in the first cycle after start is sampled (latency 1).
REQ-018 SEND: one bit per cycle, MSB of the active length first; bit_valid=1.
REQ-019 Last bit of a frame with frames remaining (or rep=0): go to GAP if GAP>0, else reload and continue SEND with no idle cycle.
REQ-020 GAP: dout=0, bit_valid=0, busy=1 for exactly GAP cycles, then SEND with a reload from the captured pattern.
REQ-021 Last bit of the final frame: go to DONE; DONE lasts one cycle with done=1, dout=0, busy=0, then IDLE.
REQ-022 stop=1 in SEND or GAP: go to IDLE next cycle with dout=0 and no done pulse.
REQ-023 start in any state other than IDLE is ignored; captured inputs do not change mid-transmission.
REQ-024 start=1 and stop=1 in the same IDLE cycle: stop wins and the block stays in IDLE.
REQ-025 The frame counter saturates and never wraps; with rep=0 no counter limits transmission.
REQ-026 pattern, len and rep changing while busy have no effect on dout.

Reset
REQ-027 rst=0 at a clock edge: state=IDLE, dout=0, bit_valid=0, busy=0, done=0, all counters and captured registers 0.
REQ-028 Reset mid-frame discards the frame with no done pulse; the block accepts start in the first cycle after rst returns to 1.

Structure
REQ-029 Package lly_seq_pkg holds the state encoding enum, the WIDTH default, and the len/rep field widths.
REQ-030 The parallel-in serial-out shift register with load/shift enable is a sub-module named lly_piso_shift.
REQ-031 The FSM, bit counter, frame counter and gap counter stay in lly_seq_gen.

Verification
REQ-032 pattern=8'h05, len=4, rep=1, start -> dout 0,1,0,1 on cycles 1-4 with bit_valid=1; done=1 on cycle 5.
REQ-033 pattern=8'h05, len=4, rep=2, GAP=0 -> 0,1,0,1,0,1,0,1 back-to-back; single done pulse; with GAP=2, two dout=0/bit_valid=0 cycles between frames.
REQ-034 rep=0, pattern=8'hA5, len=0 -> 8-bit 10100101 repeats continuously; stop -> IDLE next cycle, no done pulse.
REQ-035 start pulsed mid-frame with a new pattern -> output stream unchanged; start+stop together in IDLE -> busy stays 0.
REQ-036 rst=0 at bit 2 of a frame -> all outputs 0 next cycle; a start right after release sends a clean frame from the MSB.
